// File: rtl/jts16_pkg.sv
// Shared definitions for the object ROM slot: FSM state encoding and ROM line width.
package jts16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } obj_state_e;

  localparam int unsigned ROM_LINE_W = 32;

endpackage

// File: rtl/jts16_obj_romslot.sv
// Object ROM slot: one 32-bit line store in front of the SDRAM, serving 16-bit words.
// Optional macro JTS16_OBJ_CACHE_EN keeps the line across address changes (hits skip SDRAM).
module jts16_obj_romslot
  import jts16_pkg::*;
#(
  parameter logic [21:0] ROM_OFFSET = 22'h0,
  parameter int unsigned LATCH_DATA = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  obj_cs,
  input  logic [19:0]           obj_addr,
  output logic                  obj_ok,
  output logic [15:0]           obj_data,
  output logic                  sdram_req,
  output logic [21:0]           sdram_addr,
  input  logic                  sdram_ack,
  input  logic                  sdram_dok,
  input  logic [ROM_LINE_W-1:0] sdram_din
);

  obj_state_e            state_q, state_d;
  logic                  req_q, req_d;
  logic [21:0]           addr_q, addr_d;
  logic [18:0]           pend_q, pend_d;
  logic [18:0]           line_addr_q, line_addr_d;
  logic [ROM_LINE_W-1:0] line_data_q, line_data_d;
  logic                  line_valid_q, line_valid_d;
  logic [15:0]           data_q, data_d;
  logic                  rdy_q, rdy_d;
  logic [19:0]           rdy_addr_q, rdy_addr_d;
  logic                  eff_valid, hit, data_ready;
  logic [15:0]           word;

`ifndef JTS16_OBJ_CACHE_EN
  logic [19:0] last_addr_q;
  // Any address change invalidates the line in the same cycle it is seen.
  always_comb eff_valid = line_valid_q & (obj_addr == last_addr_q);

  always_ff @(posedge clk) begin
    if (rst) last_addr_q <= '0;
    else     last_addr_q <= obj_addr;
  end
`else
  always_comb eff_valid = line_valid_q;
`endif

  always_comb begin
    hit  = eff_valid & (obj_addr[19:1] == line_addr_q);
    word = obj_addr[0] ? line_data_q[31:16] : line_data_q[15:0];

    state_d      = state_q;
    req_d        = req_q;
    addr_d       = addr_q;
    pend_d       = pend_q;
    line_addr_d  = line_addr_q;
    line_data_d  = line_data_q;
    line_valid_d = eff_valid;
    data_d       = word;
    rdy_d        = hit;
    rdy_addr_d   = obj_addr;

    unique case (state_q)
      ST_IDLE: begin
        if (obj_cs && !hit) begin
          pend_d  = obj_addr[19:1];
          addr_d  = ROM_OFFSET + {2'b00, obj_addr[19:1], 1'b0};
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          req_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sdram_dok) begin
          line_data_d  = sdram_din;
          line_addr_d  = pend_q;
          line_valid_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_q        <= 1'b0;
      addr_q       <= '0;
      pend_q       <= '0;
      line_addr_q  <= '0;
      line_data_q  <= '0;
      line_valid_q <= 1'b0;
      data_q       <= '0;
      rdy_q        <= 1'b0;
      rdy_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      pend_q       <= pend_d;
      line_addr_q  <= line_addr_d;
      line_data_q  <= line_data_d;
      line_valid_q <= line_valid_d;
      data_q       <= data_d;
      rdy_q        <= rdy_d;
      rdy_addr_q   <= rdy_addr_d;
    end
  end

  // Registered word is only trusted when it was captured for the current address.
  generate
    if (LATCH_DATA != 0) begin : g_latch
      assign data_ready = rdy_q & (rdy_addr_q == obj_addr);
      assign obj_data   = data_q;
    end else begin : g_comb
      assign data_ready = 1'b1;
      assign obj_data   = word;
    end
  endgenerate

  assign obj_ok     = obj_cs & hit & data_ready;
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

endmodule

// File: tb/tb_jts16_obj_romslot.sv
// Directed bench for jts16_obj_romslot; honours JTS16_OBJ_CACHE_EN for the odd-word step.
module tb_jts16_obj_romslot;

  logic        clk = 1'b0;
  logic        rst;
  logic        obj_cs, b_cs;
  logic [19:0] obj_addr, b_addr;
  logic        obj_ok, b_ok;
  logic [15:0] obj_data, b_data;
  logic        sdram_req, b_req;
  logic [21:0] sdram_addr, b_sdaddr;
  logic        sdram_ack, sdram_dok;
  logic [31:0] sdram_din;
  logic        b_ack, b_dok;
  logic [31:0] b_din;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  jts16_obj_romslot #(.ROM_OFFSET(22'h0), .LATCH_DATA(1)) u_dut (
    .clk(clk), .rst(rst), .obj_cs(obj_cs), .obj_addr(obj_addr),
    .obj_ok(obj_ok), .obj_data(obj_data), .sdram_req(sdram_req),
    .sdram_addr(sdram_addr), .sdram_ack(sdram_ack), .sdram_dok(sdram_dok),
    .sdram_din(sdram_din)
  );

  jts16_obj_romslot #(.ROM_OFFSET(22'h3F_FFF0), .LATCH_DATA(1)) u_wrap (
    .clk(clk), .rst(rst), .obj_cs(b_cs), .obj_addr(b_addr),
    .obj_ok(b_ok), .obj_data(b_data), .sdram_req(b_req),
    .sdram_addr(b_sdaddr), .sdram_ack(b_ack), .sdram_dok(b_dok),
    .sdram_din(b_din)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; obj_cs = 1'b0; obj_addr = '0; sdram_ack = 1'b0; sdram_dok = 1'b0;
    sdram_din = '0; b_cs = 1'b0; b_addr = '0; b_ack = 1'b0; b_dok = 1'b0; b_din = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_req", {31'd0, sdram_req}, 32'd0);
    chk("rst_addr", {10'd0, sdram_addr}, 32'd0);
    chk("rst_ok", {31'd0, obj_ok}, 32'd0);
    chk("rst_data", {16'd0, obj_data}, 32'd0);

    // First fill: ack two cycles into REQ, dok three cycles into WAIT
    obj_cs = 1'b1; obj_addr = 20'h00010;
    tick();
    chk("f1_req", {31'd0, sdram_req}, 32'd1);
    chk("f1_addr", {10'd0, sdram_addr}, 32'h10);
    tick();
    chk("f1_req_hold", {31'd0, sdram_req}, 32'd1);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    chk("f1_req_drop", {31'd0, sdram_req}, 32'd0);
    tick(); tick();
    sdram_dok = 1'b1; sdram_din = 32'hBEEF_CAFE;
    chk("f1_ok_before", {31'd0, obj_ok}, 32'd0);
    tick();
    sdram_dok = 1'b0;
    tick();
    chk("f1_ok", {31'd0, obj_ok}, 32'd1);
    chk("f1_data", {16'd0, obj_data}, 32'hCAFE);
    chk("f1_no_req", {31'd0, sdram_req}, 32'd0);

    // Odd word of the same line
    obj_addr = 20'h00011;
    #1;
    chk("odd_ok_drop", {31'd0, obj_ok}, 32'd0);
`ifdef JTS16_OBJ_CACHE_EN
    tick();
    chk("odd_ok", {31'd0, obj_ok}, 32'd1);
    chk("odd_data", {16'd0, obj_data}, 32'hBEEF);
    chk("odd_no_req", {31'd0, sdram_req}, 32'd0);
`else
    tick();
    chk("odd_req", {31'd0, sdram_req}, 32'd1);
    chk("odd_addr", {10'd0, sdram_addr}, 32'h10);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    sdram_dok = 1'b1; sdram_din = 32'hBEEF_CAFE;
    tick();
    sdram_dok = 1'b0;
    tick();
    chk("odd_ok", {31'd0, obj_ok}, 32'd1);
    chk("odd_data", {16'd0, obj_data}, 32'hBEEF);
`endif

    // Address moves during WAIT: old line stored, then refetch of the new one
    obj_addr = 20'h00020;
    tick();
    chk("mv_req", {31'd0, sdram_req}, 32'd1);
    chk("mv_addr", {10'd0, sdram_addr}, 32'h20);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    obj_addr = 20'h00100;
    tick();
    chk("mv_ok_wait", {31'd0, obj_ok}, 32'd0);
    sdram_dok = 1'b1; sdram_din = 32'h1234_5678;
    tick();
    sdram_dok = 1'b0;
    chk("mv_ok_idle", {31'd0, obj_ok}, 32'd0);
    tick();
    chk("mv_req2", {31'd0, sdram_req}, 32'd1);
    chk("mv_addr2", {10'd0, sdram_addr}, 32'h100);
    chk("mv_ok_req", {31'd0, obj_ok}, 32'd0);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    sdram_dok = 1'b1; sdram_din = 32'hAAAA_5555;
    tick();
    sdram_dok = 1'b0;
    tick();
    chk("mv_ok", {31'd0, obj_ok}, 32'd1);
    chk("mv_data", {16'd0, obj_data}, 32'h5555);

    // Reset during WAIT, then a late dok
    obj_addr = 20'h00200;
    tick();
    chk("rw_req", {31'd0, sdram_req}, 32'd1);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    rst = 1'b1; obj_cs = 1'b0;
    tick();
    rst = 1'b0;
    sdram_dok = 1'b1; sdram_din = 32'hDEAD_BEEF;
    tick();
    sdram_dok = 1'b0;
    chk("rw_req_after", {31'd0, sdram_req}, 32'd0);
    obj_cs = 1'b1;
    #1;
    chk("rw_ok_after", {31'd0, obj_ok}, 32'd0);
    obj_cs = 1'b0;

    // No request while obj_cs is low
    obj_addr = 20'h00300;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("cs_low_req", {31'd0, sdram_req}, 32'd0);
    end

    // ROM_OFFSET wraps modulo 2^22
    b_cs = 1'b1; b_addr = 20'h00020;
    tick();
    chk("wrap_req", {31'd0, b_req}, 32'd1);
    chk("wrap_addr", {10'd0, b_sdaddr}, 32'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
